// File: rtl/s_axis_module.sv
// AXI4-Stream video slave: checks frame geometry (tuser/tlast) and forwards pixels to the kernel stage.
// Latency: one cycle from an accepted beat to o_pixel_valid and its status pulses.
// Backpressure: s_axis_tready is i_enable registered once; downstream cannot stall the block.
module s_axis_module #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_WIDTH  = 10,
    parameter int IMG_HEIGHT = 10
) (
    input  logic                  i_clk,
    input  logic                  i_aresetn,
    input  logic                  i_enable,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tuser,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] o_pixel,
    output logic                  o_pixel_valid,
    output logic                  o_start_of_frame,
    output logic                  o_frame_done,
    output logic                  o_err_early_eol,
    output logic                  o_err_late_eol,
    output logic [7:0]            o_err_count
);

    localparam logic [11:0] LAST_COL  = 12'(IMG_WIDTH - 1);
    localparam logic [11:0] LAST_LINE = 12'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {WAIT_SOF, ACTIVE, RESYNC} state_t;

    state_t      state_q, state_d;
    logic [11:0] col_q, col_d;
    logic [11:0] line_q, line_d;
    logic        beat;
    logic        emit;
    logic        sof_d;
    logic        done_d;
    logic        early_d;
    logic        late_d;
    logic        err_evt;

    assign beat = s_axis_tvalid & s_axis_tready;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        line_d  = line_q;
        emit    = 1'b0;
        sof_d   = 1'b0;
        done_d  = 1'b0;
        early_d = 1'b0;
        late_d  = 1'b0;
        err_evt = 1'b0;
        if (beat) begin
            unique case (state_q)
                WAIT_SOF, RESYNC: begin
                    if (s_axis_tuser) begin
                        emit    = 1'b1;
                        sof_d   = 1'b1;
                        col_d   = 12'd1;
                        line_d  = 12'd0;
                        state_d = ACTIVE;
                    end
                end
                ACTIVE: begin
                    emit = 1'b1;
                    // A fresh SOF wins over any line-length check on the same beat
                    if (s_axis_tuser) begin
                        sof_d   = 1'b1;
                        col_d   = 12'd1;
                        line_d  = 12'd0;
                        err_evt = 1'b1;
                    end else if (s_axis_tlast && (col_q < LAST_COL)) begin
                        early_d = 1'b1;
                        err_evt = 1'b1;
                        col_d   = 12'd0;
                        line_d  = 12'd0;
                        state_d = RESYNC;
                    end else if (!s_axis_tlast && (col_q == LAST_COL)) begin
                        late_d  = 1'b1;
                        err_evt = 1'b1;
                        col_d   = 12'd0;
                        line_d  = 12'd0;
                        state_d = RESYNC;
                    end else if (s_axis_tlast) begin
                        col_d = 12'd0;
                        if (line_q == LAST_LINE) begin
                            done_d  = 1'b1;
                            line_d  = 12'd0;
                            state_d = WAIT_SOF;
                        end else begin
                            line_d = line_q + 12'd1;
                        end
                    end else begin
                        col_d = col_q + 12'd1;
                    end
                end
                default: state_d = WAIT_SOF;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state_q <= WAIT_SOF;
            col_q   <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            line_q  <= line_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            s_axis_tready    <= 1'b0;
            o_pixel          <= '0;
            o_pixel_valid    <= 1'b0;
            o_start_of_frame <= 1'b0;
            o_frame_done     <= 1'b0;
            o_err_early_eol  <= 1'b0;
            o_err_late_eol   <= 1'b0;
            o_err_count      <= '0;
        end else begin
            s_axis_tready    <= i_enable;
            o_pixel_valid    <= emit;
            o_start_of_frame <= sof_d;
            o_frame_done     <= done_d;
            o_err_early_eol  <= early_d;
            o_err_late_eol   <= late_d;
            if (emit) begin
                o_pixel <= s_axis_tdata;
            end
            if (err_evt && (o_err_count != 8'hFF)) begin
                o_err_count <= o_err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_s_axis_module.sv
// Randomized scoreboard bench for s_axis_module: a frame-position model predicts every output beat.
module tb_s_axis_module;

    localparam int DW = 32;
    localparam int W  = 10;
    localparam int H  = 10;

    logic          i_clk = 1'b0;
    logic          i_aresetn;
    logic          i_enable;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tuser;
    logic          s_axis_tlast;
    logic [DW-1:0] o_pixel;
    logic          o_pixel_valid;
    logic          o_start_of_frame;
    logic          o_frame_done;
    logic          o_err_early_eol;
    logic          o_err_late_eol;
    logic [7:0]    o_err_count;

    s_axis_module #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .i_clk            (i_clk),
        .i_aresetn        (i_aresetn),
        .i_enable         (i_enable),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tready    (s_axis_tready),
        .s_axis_tuser     (s_axis_tuser),
        .s_axis_tlast     (s_axis_tlast),
        .o_pixel          (o_pixel),
        .o_pixel_valid    (o_pixel_valid),
        .o_start_of_frame (o_start_of_frame),
        .o_frame_done     (o_frame_done),
        .o_err_early_eol  (o_err_early_eol),
        .o_err_late_eol   (o_err_late_eol),
        .o_err_count      (o_err_count)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [DW-1:0] d;
        logic          u;
        logic          l;
    } beat_t;

    typedef struct {
        logic [DW-1:0] d;
        logic          sof;
        logic          done;
        logic          early;
        logic          late;
        logic [7:0]    err;
    } exp_t;

    beat_t         stim_q[$];
    exp_t          exp_q[$];
    int            n_vec = 0;
    int            n_err = 0;
    bit            rdy_m = 1'b0;
    bit            m_sync = 1'b0;
    int            m_idx = 0;
    int            m_err = 0;
    logic [DW-1:0] last_d = '0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: a frame is a run of W*H beats addressed by a linear index
    task automatic push_exp(input logic [DW-1:0] d, input bit sof, input bit done,
                            input bit early, input bit late);
        exp_t e;
        e.d = d; e.sof = sof; e.done = done; e.early = early; e.late = late;
        e.err = 8'(m_err);
        exp_q.push_back(e);
    endtask

    task automatic bump_err();
        if (m_err < 255) m_err++;
    endtask

    task automatic model_beat(input beat_t b);
        bit eol_pos;
        if (b.u) begin
            if (m_sync) bump_err();
            m_sync = 1'b1;
            m_idx  = 1;
            push_exp(b.d, 1'b1, 1'b0, 1'b0, 1'b0);
        end else if (m_sync) begin
            eol_pos = ((m_idx % W) == W - 1);
            if (b.l && !eol_pos) begin
                bump_err(); m_sync = 1'b0;
                push_exp(b.d, 1'b0, 1'b0, 1'b1, 1'b0);
            end else if (!b.l && eol_pos) begin
                bump_err(); m_sync = 1'b0;
                push_exp(b.d, 1'b0, 1'b0, 1'b0, 1'b1);
            end else if (m_idx == W * H - 1) begin
                m_sync = 1'b0;
                push_exp(b.d, 1'b0, 1'b1, 1'b0, 1'b0);
            end else begin
                m_idx++;
                push_exp(b.d, 1'b0, 1'b0, 1'b0, 1'b0);
            end
        end
    endtask

    task automatic add_beat(input logic [DW-1:0] d, input logic u, input logic l);
        beat_t b;
        b.d = d; b.u = u; b.l = l;
        stim_q.push_back(b);
    endtask

    // kind: 0 clean, 1 extra tlast at (eline,ecol), 2 missing tlast on eline, 3 stop before (eline,ecol)
    task automatic add_frame(input int base, input int kind, input int eline, input int ecol);
        for (int idx = 0; idx < W * H; idx++) begin
            int  ln = idx / W;
            int  cl = idx % W;
            logic l = (cl == W - 1);
            if (kind == 3 && ln == eline && cl == ecol) return;
            if (kind == 1 && ln == eline && cl == ecol) l = 1'b1;
            if (kind == 2 && ln == eline && cl == W - 1) l = 1'b0;
            add_beat(DW'(base + idx), (idx == 0), l);
        end
    endtask

    task automatic check_all_zero(input string nm);
        check(nm, {18'd0, s_axis_tready, o_pixel, o_pixel_valid, o_start_of_frame,
                   o_frame_done, o_err_early_eol, o_err_late_eol, o_err_count}, 64'd0);
    endtask

    task automatic mid_reset();
        i_aresetn = 1'b0;
        #1;
        check_all_zero("async_reset_outputs");
        m_sync = 1'b0; m_err = 0; rdy_m = 1'b0; last_d = '0;
        exp_q.delete();
        #1;
        i_aresetn = 1'b1;
    endtask

    task automatic idle(input int n);
        s_axis_tvalid = 1'b0;
        i_enable      = 1'b1;
        repeat (n) begin
            @(posedge i_clk);
            rdy_m = i_enable;
            #1;
            check("tready_idle", 64'(s_axis_tready), 64'(rdy_m));
        end
    endtask

    task automatic run(input int vpct, input int gap_at, input int rst_at);
        int    sent = 0;
        int    cyc = 0;
        int    gap_ctr = 0;
        bit    gap_done = 1'b0;
        bit    rst_done = 1'b0;
        beat_t b;
        while (stim_q.size() > 0) begin
            if (gap_at >= 0 && !gap_done && sent == gap_at) begin
                gap_ctr = 7; gap_done = 1'b1;
            end
            i_enable = (gap_ctr == 0);
            if (gap_ctr > 0) gap_ctr--;
            b = stim_q[0];
            s_axis_tvalid = ($urandom_range(99) < vpct);
            if (s_axis_tvalid) begin
                s_axis_tdata = b.d; s_axis_tuser = b.u; s_axis_tlast = b.l;
            end else begin
                s_axis_tdata = $urandom; s_axis_tuser = 1'($urandom); s_axis_tlast = 1'($urandom);
            end
            @(posedge i_clk);
            if (s_axis_tvalid && rdy_m) begin
                model_beat(b);
                void'(stim_q.pop_front());
                sent++;
            end
            rdy_m = i_enable;
            #1;
            check("tready", 64'(s_axis_tready), 64'(rdy_m));
            if (rst_at >= 0 && !rst_done && sent == rst_at) begin
                rst_done = 1'b1;
                mid_reset();
            end
            cyc++;
            if (cyc > 20000) begin
                n_vec++; n_err++;
                $display("FAIL stim_timeout: %0d beats left, expected 0", stim_q.size());
                stim_q.delete();
            end
        end
        idle(4);
    endtask

    // Monitor: every output beat must match the head of the scoreboard
    always @(negedge i_clk) begin
        if (i_aresetn) begin
            if (o_pixel_valid | o_start_of_frame | o_frame_done | o_err_early_eol | o_err_late_eol) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_output: got pixel %0h valid %0b, expected none", o_pixel, o_pixel_valid);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("pixel_beat",
                          {20'd0, o_pixel_valid, o_pixel, o_start_of_frame, o_frame_done,
                           o_err_early_eol, o_err_late_eol, o_err_count},
                          {20'd0, 1'b1, e.d, e.sof, e.done, e.early, e.late, e.err});
                    last_d = e.d;
                end
            end else begin
                check("pixel_hold", 64'(o_pixel), 64'(last_d));
            end
        end
    end

    initial begin
        i_aresetn = 1'b1; i_enable = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tuser = 1'b0; s_axis_tlast = 1'b0;
        #1 i_aresetn = 1'b0;
        #2 check_all_zero("reset_outputs");
        i_enable = 1'b1; s_axis_tvalid = 1'b1; s_axis_tuser = 1'b1;
        repeat (2) @(posedge i_clk);
        #1 check_all_zero("reset_held_outputs");
        i_enable = 1'b0; s_axis_tvalid = 1'b0; s_axis_tuser = 1'b0;
        i_aresetn = 1'b1;
        @(posedge i_clk);
        rdy_m = i_enable;
        #1 check("tready_after_release", 64'(s_axis_tready), 64'(rdy_m));

        add_frame(0, 0, 0, 0);                         // clean frame, tvalid always high
        run(100, -1, -1);
        check("err_clean", 64'(o_err_count), 64'(m_err));

        for (int i = 0; i < 5; i++) add_beat(DW'(500 + i), 1'b0, 1'b0);
        add_frame(0, 0, 0, 0);
        run(100, -1, -1);

        add_frame(1000, 1, 2, 6);                      // early tlast
        add_frame(2000, 0, 0, 0);
        run(100, -1, -1);

        add_frame(3000, 2, 0, 0);                      // missing tlast, then mid-frame SOF
        add_frame(4000, 3, 4, 5);
        add_frame(5000, 0, 0, 0);
        run(100, -1, -1);
        check("err_after_eol_errors", 64'(o_err_count), 64'(m_err));

        add_frame(0, 0, 0, 0);                         // throttled tvalid plus enable gap
        run(60, 37, -1);

        for (int i = 0; i < 200; i++)
            add_beat($urandom, 1'($urandom_range(99) < 8), 1'($urandom_range(99) < 15));
        run(70, 50, -1);

        for (int i = 0; i < 301; i++) add_beat(DW'(9000 + i), 1'b1, 1'b0);
        run(90, -1, -1);
        check("err_saturated", 64'(o_err_count), 64'(m_err));

        add_frame(6000, 0, 0, 0);                      // reset lands mid-frame
        add_frame(7000, 0, 0, 0);
        run(80, -1, 45);
        check("err_after_reset", 64'(o_err_count), 64'(m_err));

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/s_axis_module.md
S_AXIS_MODULE -- requirements
Module: S_AXIS_module

Interface
REQ-001 Parameter DATA_WIDTH, default 32, sets the pixel and tdata width in bits.
REQ-002 Parameter IMG_WIDTH, default 10, gives the pixels per line.
REQ-003 Parameter IMG_HEIGHT, default 10, gives the lines per frame.
REQ-004 i_clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-005 i_aresetn  in  1  reset, asynchronous assert, active-low.
REQ-006 i_enable  in  1  when high, the block SHALL accept stream beats.
REQ-007 s_axis_tdata  in  DATA_WIDTH  input pixel.
REQ-008 s_axis_tvalid  in  1  input beat valid.
REQ-009 s_axis_tready  out  1  block ready; registered.
REQ-010 s_axis_tuser  in  1  start of frame; set on pixel (0,0).
REQ-011 s_axis_tlast  in  1  end of line; set on pixel IMG_WIDTH-1.
REQ-012 o_pixel  out  DATA_WIDTH  pixel to the kernel/M_AXIS stage.
REQ-013 o_pixel_valid  out  1  o_pixel qualifier, one cycle per pixel.
REQ-014 o_start_of_frame  out  1  set together with o_pixel_valid on pixel (0,0).
REQ-015 o_frame_done  out  1  one-cycle pulse after the last pixel of a frame.
REQ-016 o_err_early_eol  out  1  one-cycle pulse: tlast arrived with column < IMG_WIDTH-1.
REQ-017 o_err_late_eol  out  1  one-cycle pulse: tlast missing at column IMG_WIDTH-1.
REQ-018 o_err_count  out  8  saturating count of all error events.

Function
REQ-019 A beat SHALL occur when s_axis_tvalid and s_axis_tready are both high on a rising edge.
REQ-020 s_axis_tready SHALL equal i_enable delayed by one register stage, in every state.
REQ-021 The block SHALL hold a 12-bit column counter and a 12-bit line counter.
REQ-022 The FSM SHALL have 3 states: WAIT_SOF, ACTIVE, RESYNC.
REQ-023 In WAIT_SOF, a beat with tuser=0 SHALL be discarded with no output.
REQ-024 In WAIT_SOF, a beat with tuser=1 SHALL be output as pixel (0,0) with o_start_of_frame=1, set column=1 and line=0, and move the FSM to ACTIVE.
REQ-025 In ACTIVE, every beat SHALL be output with o_pixel=tdata and o_pixel_valid=1, one cycle after the beat (fixed latency 1).
REQ-026 In ACTIVE, a beat with column < IMG_WIDTH-1 and tlast=0 SHALL increment the column counter.
REQ-027 In ACTIVE, a beat with column = IMG_WIDTH-1 and tlast=1 SHALL clear the column counter and increment the line counter.
REQ-028 If that line is IMG_HEIGHT-1, the beat SHALL instead pulse o_frame_done together with the pixel output, clear both counters, and move the FSM to WAIT_SOF.
REQ-029 In ACTIVE, a beat with tlast=1 and column < IMG_WIDTH-1 SHALL output the pixel, pulse o_err_early_eol, and move the FSM to RESYNC.
REQ-030 In ACTIVE, a beat with tlast=0 and column = IMG_WIDTH-1 SHALL output the pixel, pulse o_err_late_eol, and move the FSM to RESYNC.
REQ-031 In ACTIVE, a beat with tuser=1 SHALL restart the frame as in REQ-024, increment o_err_count, and stay in ACTIVE; this rule has priority over the tlast checks.
REQ-032 In RESYNC, beats SHALL be discarded until a beat with tuser=1, which SHALL be handled exactly as in REQ-024.
REQ-033 o_err_count SHALL increment once per error event, saturate at 255, and clear only on reset.
REQ-034 With no beat, o_pixel_valid, o_start_of_frame, o_frame_done and the error pulses SHALL be 0, and o_pixel SHALL hold its last value.
REQ-035 A drop of i_enable mid-frame SHALL pause beats only; state and counters SHALL be held.

Reset
REQ-036 While i_aresetn=0, all outputs SHALL be 0, both counters SHALL be 0, and the FSM SHALL be in WAIT_SOF.
REQ-037 After reset release, s_axis_tready SHALL rise no earlier than the first edge with i_enable=1.
REQ-038 A reset asserted mid-frame SHALL abandon the frame; the next frame SHALL need tuser=1 before any pixel is output.

Verification
REQ-039 Clean 10x10 frame, tvalid always high, pixel value = index 0..99 -> 100 o_pixel_valid pulses carrying 0..99, o_start_of_frame with pixel 0, o_frame_done with pixel 99, o_err_count=0.
REQ-040 5 beats with tuser=0, then a clean frame -> first 5 beats dropped, then 100 pixels output, o_err_count=0.
REQ-041 tlast on column 6 of line 2 -> o_err_early_eol pulses once, the rest of that frame is dropped, the next frame outputs 100 pixels, o_err_count=1.
REQ-042 tlast missing on column 9 of line 0, then tuser=1 mid-line 4 of the next frame -> o_err_late_eol pulses, frame restarts with o_start_of_frame=1, o_err_count=2.
REQ-043 tvalid randomly toggled and i_enable low for 7 cycles mid-frame -> pixel order and counts identical to REQ-039, and s_axis_tready low one cycle after i_enable falls.
REQ-044 300 consecutive error events -> o_err_count saturates at 255; async reset mid-frame -> all outputs 0 immediately.
